// File: rtl/core_step_if.sv
// core_step_if: host command channel into the run/step controller.
// The host drives op/count with a valid strobe; the controller always accepts.
interface core_step_if #(
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;

    modport master (output cmd_valid, cmd_op, cmd_count, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_count, output cmd_ready);
endinterface

// File: rtl/core_step_ctrl.sv
// core_step_ctrl: run/step/halt controller producing the core clock-enable.
// Counts enabled cycles; all outputs except cmd_ready are registered.
module core_step_ctrl #(
    parameter int CNT_W = 16,
    parameter int CYC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    core_step_if.slave       cmd,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] remaining,
    output logic [CYC_W-1:0] cycle_count
);
    typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    state_t           state, state_nx;
    logic [CNT_W-1:0] rem_nx;
    logic             done_nx, err_nx;
    logic             is_run, is_step, is_halt, active, last;

    assign cmd.cmd_ready = 1'b1;
    assign is_run  = cmd.cmd_valid && cmd.cmd_op == OP_RUN;
    assign is_step = cmd.cmd_valid && cmd.cmd_op == OP_STEP;
    assign is_halt = cmd.cmd_valid && cmd.cmd_op == OP_HALT;
    assign active  = state != IDLE;
    assign last    = state == STEP && remaining == CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            core_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            remaining   <= '0;
            cycle_count <= '0;
        end else begin
            state       <= state_nx;
            core_en     <= state_nx != IDLE;
            busy        <= state_nx != IDLE;
            done        <= done_nx;
            err         <= err_nx;
            remaining   <= rem_nx;
            cycle_count <= cycle_count + CYC_W'(core_en);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = is_run ? RUN : (is_step && cmd.cmd_count != '0) ? STEP : IDLE;
            RUN:     state_nx = is_halt ? IDLE : RUN;
            STEP:    state_nx = (is_halt || last) ? IDLE : STEP;
            default: state_nx = IDLE;
        endcase
    end

    // A HALT landing on the final STEP edge folds into the same single done pulse.
    always_comb begin
        done_nx = (!active && is_step && cmd.cmd_count == '0) || (active && is_halt) || last;
        err_nx  = active && (is_run || is_step);
        rem_nx  = state_nx != STEP ? '0 : (state == IDLE ? cmd.cmd_count : remaining - CNT_W'(1));
    end
endmodule
